multi_warp_simt_stack_unit: RTL and testbench
=============================================

Name: multi_warp_simt_stack_unit

Overview:
Per-warp control-flow state for a compute unit, and the successor to the flat-PC warp ITS: each warp holds a parametrised-depth SIMT reconvergence stack, driven by branch-unit resolutions. It also holds per-warp block info (dp_addr, tblock_idx, tblock_id). Sits between block dispatcher, fetcher, decoder, branch unit and instruction buffer. Adds partial-mask allocation, fetch/branch-pending tracking, and a registered round-robin block-done channel.

Parameters:
PcWidth, 32, PC width
NumWarps, 8, warps per compute unit
WarpWidth, 32, threads per warp
StackDepth, 4, stack entries per warp including base (>=3)
TblockIdxBits, 4, block index width
TblockIdBits, 4, block id width
AddressWidth, 32, dp address width
WidWidth / SpWidth, derived, max(1,clog2(NumWarps)) / max(1,clog2(StackDepth))

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
warp_free_o  out  1  some warp unoccupied
allocate_warp_i  in  1  allocate request (ignored if !warp_free_o)
allocate_pc_i / allocate_act_mask_i  in  PcWidth / WarpWidth  start PC, initial mask
allocate_dp_addr_i / allocate_tblock_idx_i / allocate_tblock_id_i  in  AddressWidth / TblockIdxBits / TblockIdBits  block info
tblock_done_o / tblock_done_ready_i / tblock_done_id_o  out / in / out  1 / 1 / TblockIdBits  completion handshake
instruction_decoded_i, decode_stop_warp_i, decode_branch_i  in  1 each  decode event, stop, is-branch
decode_wid_i / decode_next_pc_i  in  WidWidth / PcWidth  decoded warp, sequential next PC
ib_all_instr_finished_i  in  NumWarps  no instructions in flight per warp
warp_selected_i / warp_ready_o  in / out  NumWarps  fetch select / fetch eligible
warp_pc_o / warp_act_mask_o / warp_subwarp_id_o  out  NumWarps x PcWidth / WarpWidth / SpWidth  top-of-stack PC, mask, stack pointer
warp_dp_addr_o / warp_tblock_idx_o  out  NumWarps x AddressWidth / TblockIdxBits  block info
bru_branch_i / bru_branch_wid_i  in  1 / WidWidth  branch resolved, for which warp
bru_taken_mask_i / bru_taken_pc_i / bru_fallthrough_pc_i / bru_reconv_pc_i  in  WarpWidth / PcWidth x3  resolution data
stack_overflow_o  out  NumWarps  sticky per-warp overflow error

Behaviour:
- Reset (sync, rst_i=1): all warps unoccupied, sp=0, pending clear, done FSM IDLE, RR ptr=0; all outputs 0 except warp_free_o=1.
- Entry = {pc, mask, rpc}. Outputs show entry[sp]; subwarp_id=sp.
- Allocate: lowest-index unoccupied warp (from registered state); entry0={allocate_pc_i, allocate_act_mask_i, 0}, sp=0, finished=0, overflow=0. Visible next cycle.
- warp_ready_o[i] = occupied & !finished & !pending & |mask. warp_selected_i[i] sets pending.
- Decode (wid w): stop -> finished=1, pending cleared (stop wins over branch). Non-branch -> top.pc=next_pc, pending cleared. Branch -> top unchanged, pending stays set until bru_branch_i for w.
- Branch resolve (warp w, M = taken_mask & top.mask): pending cleared. M==top.mask -> top.pc=taken_pc. M==0 -> top.pc=fallthrough_pc. Otherwise divergent:
  - top.pc=reconv_pc;
  - push {fallthrough_pc, top.mask&~M, reconv_pc};
  - push {taken_pc, M, reconv_pc}; sp+=2.
- Divergence with sp+2 > StackDepth-1: no push, stack_overflow_o[w]=1 (sticky until reallocation), finished=1.
- Pop: after any top.pc update (decode or uniform branch), if sp>0 and new pc == top.rpc, sp-=1 the same cycle. At most one pop per event.
- Decode and BRU same cycle: applied independently if wids differ. Same wid is illegal (assertion).
- Done FSM:
  - IDLE: candidates = occupied & finished & ib_all_instr_finished. If any, latch first candidate at/after RR ptr (wrap-around) -> VALID.
  - VALID: tblock_done_o=1, id from latched warp, stable. On ready: warp deallocated, ptr=latched+1 mod NumWarps, -> IDLE.
  - One-cycle bubble between completions.
- Assertions: selected warp occupied and ready; decode/BRU only for pending occupied warps; no select and decode of same warp in one cycle.

Test Plan:
- Allocate mask 4'b0111 pc 0x100 (WarpWidth=4) -> warp0 ready, pc 0x100, mask 0111, sp 0; second allocate -> warp1; all warps full -> warp_free_o=0, further requests ignored.
- Select warp0, decode non-branch next_pc 0x104 -> ready low one cycle, then pc 0x104, ready.
- Mask 1111 pc 0x10, branch decoded, BRU taken 0011, taken 0x40, ft 0x14, rpc 0x80 -> {0x40,0011,sp2}; next_pc 0x80 -> {0x14,1100,sp1}; next_pc 0x80 -> {0x80,1111,sp0}.
- StackDepth=3, nested divergence at sp=2 -> stack_overflow_o[w]=1, warp finished, done issued once IB drains.
- Warps 1,3,5 finished, ptr=4, ready held low -> id of warp5 held stable; ready high -> 5, then 1, then 3 in successive handshakes.
- rst_i high mid-divergence with tblock_done_o=1 -> next cycle all outputs reset values, warp_free_o=1.

Source files
------------

// File: rtl/multi_warp_simt_stack_unit.sv
// Per-warp SIMT control-flow state for one compute unit.
// Each warp owns a small reconvergence stack of {pc, mask, rpc} entries.
// Decode events and branch-unit resolutions update the top entry, push
// diverged paths and pop at reconvergence. Per-warp block info is kept
// alongside, and finished blocks are reported on a registered round-robin
// completion channel.
module multi_warp_simt_stack_unit #(
  parameter int PcWidth       = 32,
  parameter int NumWarps      = 8,
  parameter int WarpWidth     = 32,
  parameter int StackDepth    = 4,
  parameter int TblockIdxBits = 4,
  parameter int TblockIdBits  = 4,
  parameter int AddressWidth  = 32,
  parameter int WidWidth      = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  parameter int SpWidth       = (StackDepth > 1) ? $clog2(StackDepth) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  // block dispatcher
  output logic                                        warp_free_o,
  input  logic                                        allocate_warp_i,
  input  logic [PcWidth-1:0]                          allocate_pc_i,
  input  logic [WarpWidth-1:0]                        allocate_act_mask_i,
  input  logic [AddressWidth-1:0]                     allocate_dp_addr_i,
  input  logic [TblockIdxBits-1:0]                    allocate_tblock_idx_i,
  input  logic [TblockIdBits-1:0]                     allocate_tblock_id_i,
  output logic                                        tblock_done_o,
  input  logic                                        tblock_done_ready_i,
  output logic [TblockIdBits-1:0]                     tblock_done_id_o,
  // decoder
  input  logic                                        instruction_decoded_i,
  input  logic                                        decode_stop_warp_i,
  input  logic                                        decode_branch_i,
  input  logic [WidWidth-1:0]                         decode_wid_i,
  input  logic [PcWidth-1:0]                          decode_next_pc_i,
  // instruction buffer
  input  logic [NumWarps-1:0]                         ib_all_instr_finished_i,
  // fetcher
  input  logic [NumWarps-1:0]                         warp_selected_i,
  output logic [NumWarps-1:0]                         warp_ready_o,
  output logic [NumWarps-1:0][PcWidth-1:0]            warp_pc_o,
  output logic [NumWarps-1:0][WarpWidth-1:0]          warp_act_mask_o,
  output logic [NumWarps-1:0][SpWidth-1:0]            warp_subwarp_id_o,
  output logic [NumWarps-1:0][AddressWidth-1:0]       warp_dp_addr_o,
  output logic [NumWarps-1:0][TblockIdxBits-1:0]      warp_tblock_idx_o,
  // branch unit
  input  logic                                        bru_branch_i,
  input  logic [WidWidth-1:0]                         bru_branch_wid_i,
  input  logic [WarpWidth-1:0]                        bru_taken_mask_i,
  input  logic [PcWidth-1:0]                          bru_taken_pc_i,
  input  logic [PcWidth-1:0]                          bru_fallthrough_pc_i,
  input  logic [PcWidth-1:0]                          bru_reconv_pc_i,
  output logic [NumWarps-1:0]                         stack_overflow_o
);

  typedef struct packed {
    logic [PcWidth-1:0]   pc;
    logic [WarpWidth-1:0] mask;
    logic [PcWidth-1:0]   rpc;
  } entry_t;

  typedef enum logic {
    DoneIdle,
    DoneValid
  } done_state_e;

  // Per-warp control bits
  logic [NumWarps-1:0] occupied_q, occupied_d;
  logic [NumWarps-1:0] finished_q, finished_d;
  logic [NumWarps-1:0] pending_q,  pending_d;
  logic [NumWarps-1:0] overflow_q, overflow_d;
  logic [SpWidth-1:0]  sp_q [NumWarps];
  logic [SpWidth-1:0]  sp_d [NumWarps];

  // Per-warp storage
  entry_t                   stack_q    [NumWarps][StackDepth];
  entry_t                   stack_d    [NumWarps][StackDepth];
  logic [AddressWidth-1:0]  dp_addr_q  [NumWarps];
  logic [AddressWidth-1:0]  dp_addr_d  [NumWarps];
  logic [TblockIdxBits-1:0] tb_idx_q   [NumWarps];
  logic [TblockIdxBits-1:0] tb_idx_d   [NumWarps];
  logic [TblockIdBits-1:0]  tb_id_q    [NumWarps];
  logic [TblockIdBits-1:0]  tb_id_d    [NumWarps];

  // Allocation and completion channel
  logic                alloc_found;
  logic [WidWidth-1:0] alloc_wid;
  logic                alloc_fire;
  done_state_e         done_state_q;
  logic [WidWidth-1:0] rr_ptr_q;
  logic [WidWidth-1:0] done_wid_q;
  logic [NumWarps-1:0] done_cand;
  logic                cand_found;
  logic [WidWidth-1:0] cand_wid;
  logic                done_fire;

  assign warp_free_o = ~&occupied_q;
  assign alloc_fire  = allocate_warp_i & warp_free_o;
  assign done_cand   = occupied_q & finished_q & ib_all_instr_finished_i;
  assign done_fire   = (done_state_q == DoneValid) & tblock_done_ready_i;

  // Lowest-index unoccupied warp receives the next allocation
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    alloc_found = 1'b0;
    alloc_wid   = '0;
    for (int i = 0; i < NumWarps; i++) begin
      if (!occupied_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_wid   = WidWidth'(i);
      end
    end
  end

  // First completion candidate at or after the round-robin pointer
  always_comb begin
    int unsigned idx;
    idx        = 0;
    cand_found = 1'b0;
    cand_wid   = '0;
    for (int k = 0; k < NumWarps; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NumWarps) idx = idx - NumWarps;
      if (!cand_found && done_cand[idx]) begin
        cand_found = 1'b1;
        cand_wid   = WidWidth'(idx);
      end
    end
  end

  // Next-state for every warp: allocation, fetch/decode/branch events
  always_comb begin
    entry_t               top;
    logic [WarpWidth-1:0] taken_m;
    logic [SpWidth-1:0]   sp_p1;
    logic [SpWidth-1:0]   sp_p2;
    logic                 pc_write;
    logic [PcWidth-1:0]   pc_val;
    logic                 dec_hit;
    logic                 bru_hit;

    occupied_d = occupied_q;
    finished_d = finished_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    sp_d       = sp_q;
    stack_d    = stack_q;
    dp_addr_d  = dp_addr_q;
    tb_idx_d   = tb_idx_q;
    tb_id_d    = tb_id_q;
    top        = '0;
    taken_m    = '0;
    sp_p1      = '0;
    sp_p2      = '0;
    pc_write   = 1'b0;
    pc_val     = '0;
    dec_hit    = 1'b0;
    bru_hit    = 1'b0;

    for (int w = 0; w < NumWarps; w++) begin
      top      = stack_q[w][sp_q[w]];
      taken_m  = bru_taken_mask_i & top.mask;
      sp_p1    = sp_q[w] + SpWidth'(1);
      sp_p2    = sp_q[w] + SpWidth'(2);
      pc_write = 1'b0;
      pc_val   = '0;
      dec_hit  = instruction_decoded_i && (int'(decode_wid_i) == w);
      bru_hit  = bru_branch_i && (int'(bru_branch_wid_i) == w);

      if (alloc_fire && (int'(alloc_wid) == w)) begin
        occupied_d[w]  = 1'b1;
        finished_d[w]  = 1'b0;
        pending_d[w]   = 1'b0;
        overflow_d[w]  = 1'b0;
        sp_d[w]        = '0;
        stack_d[w][0]  = '{pc: allocate_pc_i, mask: allocate_act_mask_i, rpc: '0};
        dp_addr_d[w]   = allocate_dp_addr_i;
        tb_idx_d[w]    = allocate_tblock_idx_i;
        tb_id_d[w]     = allocate_tblock_id_i;
      end else begin
        if (done_fire && (int'(done_wid_q) == w)) occupied_d[w] = 1'b0;
        if (warp_selected_i[w]) pending_d[w] = 1'b1;

        // Decoder: stop beats branch; a branch keeps the warp pending
        if (dec_hit) begin
          if (decode_stop_warp_i) begin
            finished_d[w] = 1'b1;
            pending_d[w]  = 1'b0;
          end else if (!decode_branch_i) begin
            pending_d[w] = 1'b0;
            pc_write     = 1'b1;
            pc_val       = decode_next_pc_i;
          end
        end

        // Branch unit: uniform outcomes just redirect, divergence pushes
        if (bru_hit) begin
          pending_d[w] = 1'b0;
          if (taken_m == top.mask) begin
            pc_write = 1'b1;
            pc_val   = bru_taken_pc_i;
          end else if (taken_m == '0) begin
            pc_write = 1'b1;
            pc_val   = bru_fallthrough_pc_i;
          end else if (int'(sp_q[w]) + 2 > StackDepth - 1) begin
            overflow_d[w] = 1'b1;
            finished_d[w] = 1'b1;
          end else begin
            stack_d[w][sp_q[w]].pc = bru_reconv_pc_i;
            stack_d[w][sp_p1] = '{pc: bru_fallthrough_pc_i,
                                  mask: top.mask & ~taken_m,
                                  rpc: bru_reconv_pc_i};
            stack_d[w][sp_p2] = '{pc: bru_taken_pc_i,
                                  mask: taken_m,
                                  rpc: bru_reconv_pc_i};
            sp_d[w] = sp_p2;
          end
        end

        // A path that reaches its reconvergence point is popped at once
        if (pc_write) begin
          stack_d[w][sp_q[w]].pc = pc_val;
          if ((sp_q[w] != '0) && (pc_val == top.rpc)) sp_d[w] = sp_q[w] - SpWidth'(1);
        end
      end
    end
  end

  // Control bits carry reset; they decide whether storage is meaningful
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples pre-edge values; the combinational block above uses blocking.
    if (rst_i) begin
      occupied_q <= '0;
      finished_q <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      for (int w = 0; w < NumWarps; w++) sp_q[w] <= '0;
    end else begin
      occupied_q <= occupied_d;
      finished_q <= finished_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      sp_q       <= sp_d;
    end
  end

  // Stack and block-info storage
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; allocation writes every field that is
    // later read, and outputs of unoccupied warps are forced to zero.
    stack_q   <= stack_d;
    dp_addr_q <= dp_addr_d;
    tb_idx_q  <= tb_idx_d;
    tb_id_q   <= tb_id_d;
  end

  // Completion channel FSM with registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_state_q     <= DoneIdle;
      rr_ptr_q         <= '0;
      done_wid_q       <= '0;
      tblock_done_o    <= 1'b0;
      tblock_done_id_o <= '0;
    end else begin
      case (done_state_q)
        DoneIdle: begin
          if (cand_found) begin
            done_state_q     <= DoneValid;
            done_wid_q       <= cand_wid;
            tblock_done_o    <= 1'b1;
            tblock_done_id_o <= tb_id_q[cand_wid];
          end
        end
        DoneValid: begin
          if (tblock_done_ready_i) begin
            done_state_q     <= DoneIdle;
            tblock_done_o    <= 1'b0;
            tblock_done_id_o <= '0;
            rr_ptr_q         <= (int'(done_wid_q) == NumWarps - 1) ? '0
                                                                  : done_wid_q + WidWidth'(1);
          end
        end
        default: done_state_q <= DoneIdle;
      endcase
    end
  end

  // Fetch-side view: top-of-stack of each occupied warp
  always_comb begin
    for (int w = 0; w < NumWarps; w++) begin
      warp_ready_o[w]      = occupied_q[w] & ~finished_q[w] & ~pending_q[w]
                             & (|stack_q[w][sp_q[w]].mask);
      warp_pc_o[w]         = occupied_q[w] ? stack_q[w][sp_q[w]].pc   : '0;
      warp_act_mask_o[w]   = occupied_q[w] ? stack_q[w][sp_q[w]].mask : '0;
      warp_subwarp_id_o[w] = occupied_q[w] ? sp_q[w]                  : '0;
      warp_dp_addr_o[w]    = occupied_q[w] ? dp_addr_q[w]             : '0;
      warp_tblock_idx_o[w] = occupied_q[w] ? tb_idx_q[w]              : '0;
    end
  end

  assign stack_overflow_o = overflow_q;

  // Interface protocol checks
  a_select_ready: assert property (@(posedge clk_i) disable iff (rst_i)
    (warp_selected_i & ~warp_ready_o) == '0);
  a_decode_pending: assert property (@(posedge clk_i) disable iff (rst_i)
    instruction_decoded_i |-> (occupied_q[decode_wid_i] && pending_q[decode_wid_i]));
  a_bru_pending: assert property (@(posedge clk_i) disable iff (rst_i)
    bru_branch_i |-> (occupied_q[bru_branch_wid_i] && pending_q[bru_branch_wid_i]));
  a_decode_bru_wid: assert property (@(posedge clk_i) disable iff (rst_i)
    (instruction_decoded_i && bru_branch_i) |-> (decode_wid_i != bru_branch_wid_i));
  a_select_decode: assert property (@(posedge clk_i) disable iff (rst_i)
    instruction_decoded_i |-> !warp_selected_i[decode_wid_i]);

endmodule

// File: tb/tb_multi_warp_simt_stack_unit.sv
// Bench for multi_warp_simt_stack_unit: directed scenarios followed by
// legal random traffic, all compared against a queue-based stack model.
module tb_multi_warp_simt_stack_unit;

  localparam int NW   = 8;
  localparam int PCW  = 16;
  localparam int WW   = 4;
  localparam int SD   = 3;
  localparam int IXB  = 4;
  localparam int IDB  = 4;
  localparam int AW   = 16;
  localparam int WIDW = 3;
  localparam int SPW  = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  logic warp_free_o, allocate_warp_i;
  logic [PCW-1:0] allocate_pc_i;
  logic [WW-1:0]  allocate_act_mask_i;
  logic [AW-1:0]  allocate_dp_addr_i;
  logic [IXB-1:0] allocate_tblock_idx_i;
  logic [IDB-1:0] allocate_tblock_id_i;
  logic tblock_done_o, tblock_done_ready_i;
  logic [IDB-1:0] tblock_done_id_o;
  logic instruction_decoded_i, decode_stop_warp_i, decode_branch_i;
  logic [WIDW-1:0] decode_wid_i;
  logic [PCW-1:0]  decode_next_pc_i;
  logic [NW-1:0]   ib_all_instr_finished_i, warp_selected_i, warp_ready_o;
  logic [NW-1:0][PCW-1:0] warp_pc_o;
  logic [NW-1:0][WW-1:0]  warp_act_mask_o;
  logic [NW-1:0][SPW-1:0] warp_subwarp_id_o;
  logic [NW-1:0][AW-1:0]  warp_dp_addr_o;
  logic [NW-1:0][IXB-1:0] warp_tblock_idx_o;
  logic bru_branch_i;
  logic [WIDW-1:0] bru_branch_wid_i;
  logic [WW-1:0]   bru_taken_mask_i;
  logic [PCW-1:0]  bru_taken_pc_i, bru_fallthrough_pc_i, bru_reconv_pc_i;
  logic [NW-1:0]   stack_overflow_o;

  always #5 clk_i = ~clk_i;

  multi_warp_simt_stack_unit #(
    .PcWidth(PCW), .NumWarps(NW), .WarpWidth(WW), .StackDepth(SD),
    .TblockIdxBits(IXB), .TblockIdBits(IDB), .AddressWidth(AW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .warp_free_o(warp_free_o), .allocate_warp_i(allocate_warp_i),
    .allocate_pc_i(allocate_pc_i), .allocate_act_mask_i(allocate_act_mask_i),
    .allocate_dp_addr_i(allocate_dp_addr_i), .allocate_tblock_idx_i(allocate_tblock_idx_i),
    .allocate_tblock_id_i(allocate_tblock_id_i),
    .tblock_done_o(tblock_done_o), .tblock_done_ready_i(tblock_done_ready_i),
    .tblock_done_id_o(tblock_done_id_o),
    .instruction_decoded_i(instruction_decoded_i), .decode_stop_warp_i(decode_stop_warp_i),
    .decode_branch_i(decode_branch_i), .decode_wid_i(decode_wid_i),
    .decode_next_pc_i(decode_next_pc_i),
    .ib_all_instr_finished_i(ib_all_instr_finished_i),
    .warp_selected_i(warp_selected_i), .warp_ready_o(warp_ready_o),
    .warp_pc_o(warp_pc_o), .warp_act_mask_o(warp_act_mask_o),
    .warp_subwarp_id_o(warp_subwarp_id_o), .warp_dp_addr_o(warp_dp_addr_o),
    .warp_tblock_idx_o(warp_tblock_idx_o),
    .bru_branch_i(bru_branch_i), .bru_branch_wid_i(bru_branch_wid_i),
    .bru_taken_mask_i(bru_taken_mask_i), .bru_taken_pc_i(bru_taken_pc_i),
    .bru_fallthrough_pc_i(bru_fallthrough_pc_i), .bru_reconv_pc_i(bru_reconv_pc_i),
    .stack_overflow_o(stack_overflow_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [WW-1:0]  mask;
    logic [PCW-1:0] rpc;
  } ment_t;

  ment_t          m_stk [NW][$];
  bit             m_occ [NW];
  bit             m_fin [NW];
  bit             m_pend[NW];
  bit             m_ovf [NW];
  bit             m_brw [NW];   // branch decoded, waiting for resolution
  logic [AW-1:0]  m_dp  [NW];
  logic [IXB-1:0] m_idx [NW];
  logic [IDB-1:0] m_id  [NW];
  bit             m_dvalid;
  int             m_dwid;
  int             m_ptr;

  function automatic ment_t top_of(input int w);
    if (m_stk[w].size() == 0) return '0;
    return m_stk[w][m_stk[w].size()-1];
  endfunction

  function automatic bit m_ready(input int w);
    return m_occ[w] && !m_fin[w] && !m_pend[w] && (top_of(w).mask != '0);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      m_stk[w].delete();
      m_occ[w] = 0; m_fin[w] = 0; m_pend[w] = 0; m_ovf[w] = 0; m_brw[w] = 0;
      m_dp[w] = '0; m_idx[w] = '0; m_id[w] = '0;
    end
    m_dvalid = 0; m_dwid = 0; m_ptr = 0;
  endtask

  task automatic set_top_pc(input int w, input logic [PCW-1:0] p);
    int n;
    ment_t e;
    n = m_stk[w].size();
    e = m_stk[w][n-1];
    e.pc = p;
    m_stk[w][n-1] = e;
    if (n > 1 && p == e.rpc) void'(m_stk[w].pop_back());
  endtask

  task automatic model_tick();
    int aw, lw, idx, n, dw, bw;
    bit latch, dfire;
    ment_t e;
    logic [WW-1:0] m;
    if (rst_i) begin
      model_reset();
      return;
    end
    aw = -1;
    for (int i = 0; i < NW; i++) if (!m_occ[i] && aw < 0) aw = i;
    dfire = m_dvalid && tblock_done_ready_i;
    latch = 0; lw = 0;
    if (!m_dvalid)
      for (int k = 0; k < NW; k++) begin
        idx = (m_ptr + k) % NW;
        if (!latch && m_occ[idx] && m_fin[idx] && ib_all_instr_finished_i[idx]) begin
          latch = 1; lw = idx;
        end
      end
    if (allocate_warp_i && aw >= 0) begin
      m_stk[aw].delete();
      m_stk[aw].push_back('{pc: allocate_pc_i, mask: allocate_act_mask_i, rpc: '0});
      m_occ[aw] = 1; m_fin[aw] = 0; m_pend[aw] = 0; m_ovf[aw] = 0; m_brw[aw] = 0;
      m_dp[aw] = allocate_dp_addr_i; m_idx[aw] = allocate_tblock_idx_i;
      m_id[aw] = allocate_tblock_id_i;
    end
    for (int i = 0; i < NW; i++) if (warp_selected_i[i]) m_pend[i] = 1;
    if (instruction_decoded_i) begin
      dw = int'(decode_wid_i);
      if (decode_stop_warp_i) begin
        m_fin[dw] = 1; m_pend[dw] = 0; m_brw[dw] = 0;
      end else if (decode_branch_i) begin
        m_brw[dw] = 1;
      end else begin
        m_pend[dw] = 0;
        set_top_pc(dw, decode_next_pc_i);
      end
    end
    if (bru_branch_i) begin
      bw = int'(bru_branch_wid_i);
      m_pend[bw] = 0; m_brw[bw] = 0;
      e = top_of(bw);
      m = bru_taken_mask_i & e.mask;
      n = m_stk[bw].size();
      if (m == e.mask) set_top_pc(bw, bru_taken_pc_i);
      else if (m == '0) set_top_pc(bw, bru_fallthrough_pc_i);
      else if (n + 2 > SD) begin
        m_ovf[bw] = 1; m_fin[bw] = 1;
      end else begin
        e.pc = bru_reconv_pc_i;
        m_stk[bw][n-1] = e;
        m_stk[bw].push_back('{pc: bru_fallthrough_pc_i, mask: e.mask & ~m, rpc: bru_reconv_pc_i});
        m_stk[bw].push_back('{pc: bru_taken_pc_i, mask: m, rpc: bru_reconv_pc_i});
      end
    end
    if (dfire) begin
      m_occ[m_dwid] = 0;
      m_ptr = (m_dwid + 1) % NW;
      m_dvalid = 0;
    end else if (latch) begin
      m_dvalid = 1; m_dwid = lw;
    end
  endtask

  task automatic compare_all();
    logic [NW-1:0] er, eo;
    logic [63:0] ew, gw;
    bit all_occ;
    ment_t e;
    all_occ = 1;
    for (int w = 0; w < NW; w++) begin
      er[w] = m_ready(w);
      eo[w] = m_ovf[w];
      if (!m_occ[w]) all_occ = 0;
    end
    check("warp_free", 64'(warp_free_o), 64'(!all_occ));
    check("warp_ready", 64'(warp_ready_o), 64'(er));
    check("overflow", 64'(stack_overflow_o), 64'(eo));
    check("done_valid", 64'(tblock_done_o), 64'(m_dvalid));
    if (m_dvalid) check("done_id", 64'(tblock_done_id_o), 64'(m_id[m_dwid]));
    for (int w = 0; w < NW; w++) begin
      e  = top_of(w);
      ew = m_occ[w] ? 64'({e.pc, e.mask, SPW'(m_stk[w].size()-1), m_dp[w], m_idx[w]}) : 64'(0);
      gw = 64'({warp_pc_o[w], warp_act_mask_o[w], warp_subwarp_id_o[w],
                warp_dp_addr_o[w], warp_tblock_idx_o[w]});
      check($sformatf("warp%0d{pc,mask,sp,dp,idx}", w), gw, ew);
    end
  endtask

  // One clock: DUT and model advance on the same edge, then compare
  task automatic step();
    @(posedge clk_i);
    model_tick();
    #1;
    compare_all();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    allocate_warp_i = 0; warp_selected_i = '0; instruction_decoded_i = 0;
    decode_stop_warp_i = 0; decode_branch_i = 0; bru_branch_i = 0;
  endtask

  task automatic tick();
    idle();
    step();
  endtask

  task automatic do_alloc(input logic [PCW-1:0] pc, input logic [WW-1:0] mask,
                          input logic [AW-1:0] dp, input logic [IXB-1:0] ix,
                          input logic [IDB-1:0] id);
    idle();
    allocate_warp_i = 1; allocate_pc_i = pc; allocate_act_mask_i = mask;
    allocate_dp_addr_i = dp; allocate_tblock_idx_i = ix; allocate_tblock_id_i = id;
    step();
  endtask

  task automatic do_select(input int w);
    idle();
    warp_selected_i[w] = 1'b1;
    step();
  endtask

  task automatic do_decode(input int w, input bit stop, input bit br, input logic [PCW-1:0] npc);
    idle();
    instruction_decoded_i = 1; decode_wid_i = WIDW'(w);
    decode_stop_warp_i = stop; decode_branch_i = br; decode_next_pc_i = npc;
    step();
  endtask

  task automatic do_bru(input int w, input logic [WW-1:0] tm, input logic [PCW-1:0] tpc,
                        input logic [PCW-1:0] fpc, input logic [PCW-1:0] rpc);
    idle();
    bru_branch_i = 1; bru_branch_wid_i = WIDW'(w); bru_taken_mask_i = tm;
    bru_taken_pc_i = tpc; bru_fallthrough_pc_i = fpc; bru_reconv_pc_i = rpc;
    step();
  endtask

  task automatic gen_random();
    int dq[$], bq[$], sq[$];
    int dw, bw;
    ment_t e;
    idle();
    dw = -1;
    ib_all_instr_finished_i = NW'($urandom | $urandom);
    tblock_done_ready_i = ($urandom_range(0, 2) != 0);
    if ($urandom_range(0, 3) == 0) begin
      allocate_warp_i = 1;
      allocate_pc_i = PCW'($urandom_range(0, 255));
      allocate_act_mask_i = WW'($urandom_range(1, 15));
      allocate_dp_addr_i = AW'($urandom);
      allocate_tblock_idx_i = IXB'($urandom);
      allocate_tblock_id_i = IDB'($urandom);
    end
    for (int w = 0; w < NW; w++) begin
      if (m_occ[w] && m_pend[w] && !m_brw[w]) dq.push_back(w);
      if (m_occ[w] && m_brw[w]) bq.push_back(w);
      if (m_ready(w)) sq.push_back(w);
    end
    if (dq.size() > 0 && $urandom_range(0, 3) != 0) begin
      dw = dq[$urandom_range(0, dq.size()-1)];
      e = top_of(dw);
      instruction_decoded_i = 1; decode_wid_i = WIDW'(dw);
      case ($urandom_range(0, 7))
        0: begin decode_stop_warp_i = 1; decode_branch_i = 1'($urandom); end
        1, 2, 3: decode_branch_i = 1;
        default: ;
      endcase
      decode_next_pc_i = $urandom_range(0, 1) ? e.rpc : e.pc + PCW'(4);
    end
    if (bq.size() > 0 && $urandom_range(0, 3) != 0) begin
      bw = bq[$urandom_range(0, bq.size()-1)];
      e = top_of(bw);
      bru_branch_i = 1; bru_branch_wid_i = WIDW'(bw);
      bru_taken_mask_i = WW'($urandom);
      bru_taken_pc_i = ($urandom_range(0, 3) == 0) ? e.rpc : PCW'($urandom_range(0, 255));
      bru_fallthrough_pc_i = ($urandom_range(0, 3) == 0) ? e.rpc : PCW'($urandom_range(0, 255));
      bru_reconv_pc_i = PCW'($urandom_range(0, 255));
    end
    if (sq.size() > 0 && $urandom_range(0, 3) != 0)
      warp_selected_i[sq[$urandom_range(0, sq.size()-1)]] = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_i = 1;
    idle();
    allocate_pc_i = '0; allocate_act_mask_i = '0; allocate_dp_addr_i = '0;
    allocate_tblock_idx_i = '0; allocate_tblock_id_i = '0;
    decode_wid_i = '0; decode_next_pc_i = '0;
    bru_branch_wid_i = '0; bru_taken_mask_i = '0; bru_taken_pc_i = '0;
    bru_fallthrough_pc_i = '0; bru_reconv_pc_i = '0;
    ib_all_instr_finished_i = '0; tblock_done_ready_i = 0;
    model_reset();
    step();
    step();
    rst_i = 0;
    tick();
    check("rst_free", 64'(warp_free_o), 64'(1));
    check("rst_done", 64'(tblock_done_o), 64'(0));

    // Allocation order and full condition
    do_alloc(16'h0100, 4'b0111, 16'h1000, 4'd0, 4'd0);
    check("alloc0_pc", 64'(warp_pc_o[0]), 64'h100);
    check("alloc0_mask", 64'(warp_act_mask_o[0]), 64'b0111);
    check("alloc0_sp", 64'(warp_subwarp_id_o[0]), 64'(0));
    check("alloc0_ready", 64'(warp_ready_o), 64'h01);
    do_alloc(16'h0010, 4'b1111, 16'h1001, 4'd1, 4'd1);
    check("alloc1_ready", 64'(warp_ready_o), 64'h03);
    for (int k = 2; k < NW; k++)
      do_alloc(PCW'(16'h0200 + k * 16'h10), 4'b1111, AW'(16'h1000 + k), IXB'(k), IDB'(k));
    check("full_free", 64'(warp_free_o), 64'(0));
    do_alloc(16'h0999, 4'b1111, 16'h0, 4'd0, 4'd9);
    check("ignored_alloc_pc7", 64'(warp_pc_o[7]), 64'h270);

    // Non-branch decode
    do_select(0);
    check("sel0_ready", 64'(warp_ready_o[0]), 64'(0));
    do_decode(0, 0, 0, 16'h0104);
    check("dec0_pc", 64'(warp_pc_o[0]), 64'h104);
    check("dec0_ready", 64'(warp_ready_o[0]), 64'(1));

    // Divergence and reconvergence on warp1
    do_select(1);
    do_decode(1, 0, 1, 16'h0014);
    check("br1_pending", 64'(warp_ready_o[1]), 64'(0));
    do_bru(1, 4'b0011, 16'h0040, 16'h0014, 16'h0080);
    check("div_top", 64'({warp_pc_o[1], warp_act_mask_o[1], warp_subwarp_id_o[1]}),
          64'({16'h0040, 4'b0011, 2'd2}));
    do_select(1);
    do_decode(1, 0, 0, 16'h0080);
    check("pop1_top", 64'({warp_pc_o[1], warp_act_mask_o[1], warp_subwarp_id_o[1]}),
          64'({16'h0014, 4'b1100, 2'd1}));
    do_select(1);
    do_decode(1, 0, 0, 16'h0080);
    check("pop2_top", 64'({warp_pc_o[1], warp_act_mask_o[1], warp_subwarp_id_o[1]}),
          64'({16'h0080, 4'b1111, 2'd0}));

    // Nested divergence beyond the stack depth
    do_select(1);
    do_decode(1, 0, 1, 16'h0084);
    do_bru(1, 4'b0011, 16'h0050, 16'h0060, 16'h0090);
    do_select(1);
    do_decode(1, 0, 1, 16'h0054);
    do_bru(1, 4'b0001, 16'h0070, 16'h0074, 16'h0078);
    check("ovf1", 64'(stack_overflow_o), 64'h02);
    check("ovf1_ready", 64'(warp_ready_o[1]), 64'(0));
    ib_all_instr_finished_i = '1; tblock_done_ready_i = 1;
    tick();
    check("ovf_done", 64'({tblock_done_o, tblock_done_id_o}), 64'({1'b1, 4'd1}));
    tick();
    check("ovf_done_ack", 64'({tblock_done_o, warp_free_o}), 64'({1'b0, 1'b1}));

    // Completion of warp3 moves the pointer to 4
    do_select(3);
    do_decode(3, 1, 0, 16'h0);
    tick();
    check("done3_id", 64'({tblock_done_o, tblock_done_id_o}), 64'({1'b1, 4'd3}));
    tick();
    ib_all_instr_finished_i = '0;
    do_alloc(16'h0500, 4'b1010, 16'h2001, 4'd1, 4'hA);
    check("realloc1_ovf_clear", 64'(stack_overflow_o), 64'(0));
    do_alloc(16'h0600, 4'b0101, 16'h2003, 4'd3, 4'hB);
    check("realloc_full", 64'(warp_free_o), 64'(0));

    // Round-robin order 5, 1, 3 from pointer 4, with a held handshake
    for (int k = 1; k <= 5; k += 2) begin
      do_select(k);
      do_decode(k, 1, 0, 16'h0);
    end
    tblock_done_ready_i = 0; ib_all_instr_finished_i = '1;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rr_hold5", 64'({tblock_done_o, tblock_done_id_o}), 64'({1'b1, 4'd5}));
    end
    tblock_done_ready_i = 1;
    tick();
    check("rr_bubble", 64'(tblock_done_o), 64'(0));
    tick();
    check("rr_second", 64'({tblock_done_o, tblock_done_id_o}), 64'({1'b1, 4'hA}));
    tick();
    tick();
    check("rr_third", 64'({tblock_done_o, tblock_done_id_o}), 64'({1'b1, 4'hB}));
    tick();

    // Reset in the middle of a divergence with a completion offered
    do_select(0);
    do_decode(0, 0, 1, 16'h0108);
    do_bru(0, 4'b0001, 16'h0300, 16'h0304, 16'h0308);
    check("rst_div_sp", 64'(warp_subwarp_id_o[0]), 64'(2));
    do_select(2);
    do_decode(2, 1, 0, 16'h0);
    tblock_done_ready_i = 0;
    tick();
    check("rst_pre_done", 64'(tblock_done_o), 64'(1));
    rst_i = 1;
    tick();
    rst_i = 0;
    check("rst_mid_free", 64'(warp_free_o), 64'(1));
    check("rst_mid_done", 64'({tblock_done_o, tblock_done_id_o}), 64'(0));
    check("rst_mid_ready", 64'(warp_ready_o), 64'(0));
    check("rst_mid_w0", 64'({warp_pc_o[0], warp_act_mask_o[0], warp_subwarp_id_o[0]}), 64'(0));

    // Legal random traffic
    for (int c = 0; c < 3000; c++) begin
      gen_random();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
